text_pixel_mixer: RTL
=====================

// Module: text_pixel_mixer
// PURPOSE
//  Downstream stage of the text overlay. Consumes the overlay's 1-bit glyph stream (o_data/o_rd_dv)
//  and the raw timing from the video signal generator. Delay-aligns sync/DE/background to the
//  overlay read latency, composites foreground/box/background colours into RGB and drives the
//  video output. Colour changes are double-buffered and take effect only at frame boundaries.
// PARAMETERS
//  CW          8          bits per colour channel; pixel width = 3*CW
//  RD_LATENCY  2          cycles from i_rd_en high to the matching i_txt_dv/i_txt_data; must be >= 1
//  DEFAULT_FG  24'hFFFFFF reset value of the active foreground colour
//  DEFAULT_BOX 24'h000080 reset value of the active box colour
//  BLINK_FRAMES 30        frames per blink half-period (used only with TEXT_BLINK_EN)
// PORTS
//  i_clk        in  1     pixel clock
//  i_reset      in  1     synchronous, active-high reset
//  i_hsync      in  1     from generator
//  i_vsync      in  1     from generator
//  i_de         in  1     data enable from generator
//  i_nf         in  1     new-frame pulse from generator (1 cycle)
//  i_bg_rgb     in  3*CW  underlying video pixel, aligned with i_de
//  o_rd_en      out 1     read enable to overlay (= i_de, combinational)
//  i_txt_dv     in  1     overlay data valid
//  i_txt_data   in  1     overlay glyph bit (1 = foreground)
//  i_box_en     in  1     1: non-glyph text-area pixels show box colour; 0: background shows through
//  i_blink      in  1     1: blink foreground (ignored without TEXT_BLINK_EN)
//  i_color_wr   in  1     write strobe for shadow colours
//  i_fg_color   in  3*CW  shadow foreground, captured on i_color_wr
//  i_box_color  in  3*CW  shadow box colour, captured on i_color_wr
//  o_color_ack  out 1     1-cycle pulse, the cycle after each accepted i_color_wr
//  o_busy       out 1     shadow colours pending, not yet applied
//  o_hsync      out 1     delayed hsync
//  o_vsync      out 1     delayed vsync
//  o_de         out 1     delayed DE
//  o_rgb        out 3*CW  composited pixel
// BEHAVIOUR
//  - Reset: o_hsync/o_vsync/o_de/o_rgb/o_color_ack/o_busy = 0; all delay stages cleared;
//    active fg = DEFAULT_FG, active box = DEFAULT_BOX; shadow = active; blink phase = 0, frame count = 0.
//  - Alignment: hsync, vsync, de, bg_rgb pass through an RD_LATENCY-deep shift register (stage d).
//  - Mix, evaluated at stage d, registered into outputs (total latency RD_LATENCY+1, all outputs equal):
//      !de_d                      -> o_rgb = 0
//      txt_dv & txt_data & !hide  -> active fg
//      txt_dv & box_en            -> active box
//      else                       -> bg_d
//    hide = 0 without TEXT_BLINK_EN.
//  - i_txt_dv while de_d = 0 is ignored (o_rgb stays 0).
//  - Colour update FSM:
//      IDLE    -> i_color_wr: capture shadow, ack next cycle, -> PENDING
//      PENDING -> i_color_wr: overwrite shadow, ack again, stay
//      PENDING -> i_nf: active <= shadow, -> IDLE
//    A write in the same cycle as i_nf is applied at that boundary (shadow-next copied).
//    o_busy = (state == PENDING), registered. i_nf in IDLE without a write: no change.
//  - Active colours change only at i_nf, never mid-frame (no tearing).
//  - Reset mid-frame or mid-pending: pending write discarded, defaults restored; next frame is clean.
// CONFIGURATION
//  TEXT_BLINK_EN defined: frame counter increments on i_nf, wraps at BLINK_FRAMES-1 and toggles
//    blink phase. hide = i_blink & phase. Phase/counter run regardless of i_blink; reset to 0.
//  TEXT_BLINK_EN undefined: no counter/phase logic; i_blink unconnected internally; hide = 0.
// TESTING
//  1 Reset, i_de=1, i_bg_rgb=24'h123456, no txt_dv -> after RD_LATENCY+1 cycles o_rgb=24'h123456, o_de=1.
//  2 txt_dv=1,data=1 with RD_LATENCY offset -> o_rgb=24'hFFFFFF; data=0, box_en=1 -> 24'h000080;
//    data=0, box_en=0 -> bg.
//  3 hsync/vsync/de pattern from generator -> outputs identical, delayed exactly RD_LATENCY+1 cycles.
//  4 Mid-frame i_color_wr fg=24'hFF0000 -> ack next cycle, o_busy=1, glyphs still white until i_nf;
//    red from first glyph of next frame, o_busy=0.
//  5 Two writes (red then green) before i_nf; write coincident with i_nf -> two acks, green applied;
//    coincident value applied at that i_nf.
//  6 TEXT_BLINK_EN, BLINK_FRAMES=2, i_blink=1 -> glyph pixels fg for frames 0-1, box/bg for 2-3,
//    repeat; without macro glyph always fg.

Source files
------------

// File: rtl/text_pixel_mixer.sv
// text_pixel_mixer: aligns timing to overlay read latency and composites glyph/box/background (optional blink: TEXT_BLINK_EN)
module text_pixel_mixer #(
   parameter int              CW           = 8,
   parameter int              RD_LATENCY   = 2,
   parameter logic [3*CW-1:0] DEFAULT_FG   = 24'hFFFFFF,
   parameter logic [3*CW-1:0] DEFAULT_BOX  = 24'h000080,
   parameter int              BLINK_FRAMES = 30
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_hsync,
   input  logic            i_vsync,
   input  logic            i_de,
   input  logic            i_nf,
   input  logic [3*CW-1:0] i_bg_rgb,
   output logic            o_rd_en,
   input  logic            i_txt_dv,
   input  logic            i_txt_data,
   input  logic            i_box_en,
   input  logic            i_blink,
   input  logic            i_color_wr,
   input  logic [3*CW-1:0] i_fg_color,
   input  logic [3*CW-1:0] i_box_color,
   output logic            o_color_ack,
   output logic            o_busy,
   output logic            o_hsync,
   output logic            o_vsync,
   output logic            o_de,
   output logic [3*CW-1:0] o_rgb
);
   localparam int PW = 3*CW + 3;
   typedef enum logic {IDLE, PENDING} state_t;
   state_t          state, state_nx;
   logic [PW-1:0]   pipe [RD_LATENCY];
   logic [3*CW-1:0] fg, box, sh_fg, sh_box, fg_nx, box_nx, sh_fg_nx, sh_box_nx, bg_d, rgb_nx;
   logic            hs_d, vs_d, de_d, hide;
   assign o_rd_en = i_de;
   assign {hs_d, vs_d, de_d, bg_d} = pipe[RD_LATENCY-1];
   assign o_busy = (state == PENDING);
   // timing/background delay line matching the overlay read latency
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= {i_hsync, i_vsync, i_de, i_bg_rgb};
         for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end
   // compositing priority: blanking, glyph, box, background
   always_comb begin
      rgb_nx = !de_d ? '0 : (i_txt_dv && i_txt_data && !hide) ? fg : (i_txt_dv && i_box_en) ? box : bg_d;
   end
   // output register, one stage after the aligned point
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_hsync <= 1'b0;
         o_vsync <= 1'b0;
         o_de    <= 1'b0;
         o_rgb   <= '0;
      end else begin
         o_hsync <= hs_d;
         o_vsync <= vs_d;
         o_de    <= de_d;
         o_rgb   <= rgb_nx;
      end
   end
   // shadow capture and frame-boundary promotion; a write coincident with i_nf lands immediately
   always_comb begin
      state_nx  = state;
      sh_fg_nx  = sh_fg;
      sh_box_nx = sh_box;
      fg_nx     = fg;
      box_nx    = box;
      if (i_color_wr) begin
         sh_fg_nx  = i_fg_color;
         sh_box_nx = i_box_color;
         state_nx  = PENDING;
      end
      if (i_nf && (state == PENDING || i_color_wr)) begin
         fg_nx    = sh_fg_nx;
         box_nx   = sh_box_nx;
         state_nx = IDLE;
      end
   end
   // colour state registers and write acknowledge
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         fg          <= DEFAULT_FG;
         box         <= DEFAULT_BOX;
         sh_fg       <= DEFAULT_FG;
         sh_box      <= DEFAULT_BOX;
         o_color_ack <= 1'b0;
      end else begin
         state       <= state_nx;
         fg          <= fg_nx;
         box         <= box_nx;
         sh_fg       <= sh_fg_nx;
         sh_box      <= sh_box_nx;
         o_color_ack <= i_color_wr;
      end
   end
`ifdef TEXT_BLINK_EN
   localparam int FCW = $clog2(BLINK_FRAMES + 1);
   logic [FCW-1:0] fcnt;
   logic           phase;
   assign hide = i_blink & phase;
   // frame counter toggles the blink phase every BLINK_FRAMES frames
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         fcnt  <= '0;
         phase <= 1'b0;
      end else if (i_nf) begin
         fcnt  <= (fcnt == FCW'(BLINK_FRAMES - 1)) ? '0 : fcnt + 1'b1;
         phase <= (fcnt == FCW'(BLINK_FRAMES - 1)) ? ~phase : phase;
      end
   end
`else
   logic blink_unused;
   assign blink_unused = i_blink;
   assign hide = 1'b0;
`endif
endmodule
